// File: rtl/fsm_ab_driver.sv
// fsm_ab_driver: replays a programmed list of (a,b) stimulus vectors into a
// two-input Mealy FSM, holding each vector for HOLD_CYCLES clocks and capturing
// the FSM's {y1,y0} response on the final clock of each hold.
//
// Optional build macro EXPECT_CHECK_EN: stores an expected {y1,y0} alongside
// every entry and flags/counts captured responses that differ from it.
module fsm_ab_driver #(
  parameter int DEPTH       = 8,  // pattern memory entries, power of 2
  parameter int ADDR_W      = 3,  // log2(DEPTH)
  parameter int HOLD_CYCLES = 5,  // clocks each vector is driven, >= 1
  parameter int CNT_W       = 3   // hold counter width, must hold HOLD_CYCLES-1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pat_wr_en,
  input  logic [ADDR_W-1:0] pat_wr_addr,
  input  logic [1:0]        pat_wr_data,
  input  logic [ADDR_W:0]   pat_len,
  input  logic              y1,
  input  logic              y0,
`ifdef EXPECT_CHECK_EN
  input  logic [1:0]        pat_wr_exp,
  output logic              mismatch,
  output logic [ADDR_W:0]   err_cnt,
`endif
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic              resp_valid,
  output logic [1:0]        resp_data,
  output logic [ADDR_W-1:0] resp_idx
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Largest playable length; anything requested above this is clamped.
  localparam logic [ADDR_W:0] LEN_MAX  = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  // Pattern storage. Read asynchronously: the first vector must appear on the
  // outputs right after the start edge, and successive vectors follow with no
  // gap, so a registered-read RAM would add a bubble. The memory is tiny.
  logic [1:0]        r_mem [DEPTH];

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_idx;
  logic [CNT_W-1:0]  r_hold;
  logic              r_a;
  logic              r_b;
  logic              r_busy;
  logic              r_done;
  logic              r_resp_valid;
  logic [1:0]        r_resp_data;
  logic [ADDR_W-1:0] r_resp_idx;

  logic              w_wr_accept;
  logic [ADDR_W:0]   w_len_clamped;
  logic [1:0]        w_first_ab;
  logic [ADDR_W-1:0] w_idx_inc;
  logic [1:0]        w_next_ab;
  logic              w_hold_end;
  logic              w_last;
  logic [1:0]        w_y;

  // Memory is frozen for the whole run so the replayed sequence is coherent.
  assign w_wr_accept   = pat_wr_en && (r_state != S_RUN);
  assign w_len_clamped = (pat_len > LEN_MAX) ? LEN_MAX : pat_len;

  // A write to entry 0 on the very edge that starts a run must be what gets
  // played, so forward the incoming data past the not-yet-updated array.
  assign w_first_ab = (w_wr_accept && (pat_wr_addr == '0)) ? pat_wr_data : r_mem[0];

  // Only consumed when r_idx is not the last entry, so the increment never wraps
  // into use.
  assign w_idx_inc  = r_idx + ADDR_W'(1);
  assign w_next_ab  = r_mem[w_idx_inc];

  assign w_hold_end = (r_hold == HOLD_LAST);
  assign w_last     = ({1'b0, r_idx} == (r_len - (ADDR_W+1)'(1)));
  assign w_y        = {y1, y0};

`ifdef EXPECT_CHECK_EN
  logic [1:0]      r_exp_mem [DEPTH];
  logic            r_mismatch;
  logic [ADDR_W:0] r_err_cnt;
  logic            w_cmp_fail;

  // Expected response of the entry whose hold is ending right now.
  assign w_cmp_fail = (w_y != r_exp_mem[r_idx]);
`endif

  // Pattern (and expected-response) write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[pat_wr_addr] <= pat_wr_data;
`ifdef EXPECT_CHECK_EN
      r_exp_mem[pat_wr_addr] <= pat_wr_exp;
`endif
    end
  end

  // Sequencer FSM: IDLE waits for start, RUN steps through entries, FIN pulses done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_idx        <= '0;
      r_hold       <= '0;
      r_a          <= 1'b0;
      r_b          <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_idx   <= '0;
`ifdef EXPECT_CHECK_EN
      r_mismatch   <= 1'b0;
      r_err_cnt    <= '0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      r_done       <= 1'b0;
      r_resp_valid <= 1'b0;
`ifdef EXPECT_CHECK_EN
      r_mismatch   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_a <= 1'b0;
          r_b <= 1'b0;
          if (start) begin
            r_len  <= w_len_clamped;
            r_idx  <= '0;
            r_hold <= '0;
`ifdef EXPECT_CHECK_EN
            r_err_cnt <= '0;
`endif
            if (w_len_clamped == '0) begin
              // Empty run: go straight to the done pulse, never look busy.
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_a     <= w_first_ab[1];
              r_b     <= w_first_ab[0];
            end
          end
        end

        S_RUN: begin
          if (w_hold_end) begin
            // Capture the FSM's reaction to the vector held for the full window.
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_y;
            r_resp_idx   <= r_idx;
`ifdef EXPECT_CHECK_EN
            r_mismatch <= w_cmp_fail;
            if (w_cmp_fail && (r_err_cnt != '1)) begin
              r_err_cnt <= r_err_cnt + (ADDR_W+1)'(1);
            end
`endif
            if (w_last) begin
              r_state <= S_FIN;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_a     <= 1'b0;
              r_b     <= 1'b0;
            end else begin
              // Next vector lands on the same edge: back-to-back holds.
              r_idx  <= w_idx_inc;
              r_hold <= '0;
              r_a    <= w_next_ab[1];
              r_b    <= w_next_ab[0];
            end
          end else begin
            r_hold <= r_hold + CNT_W'(1);
          end
        end

        S_FIN: begin
          // done is high for this single cycle; start is deliberately ignored.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
        end
      endcase
    end
  end

  assign a          = r_a;
  assign b          = r_b;
  assign busy       = r_busy;
  assign done       = r_done;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_idx   = r_resp_idx;
`ifdef EXPECT_CHECK_EN
  assign mismatch   = r_mismatch;
  assign err_cnt    = r_err_cnt;
`endif

endmodule

// File: tb/tb_fsm_ab_driver.sv
// Directed testbench for fsm_ab_driver. The attached "FSM" is a tiny
// combinational stand-in: y1 = a & ~b, y0 = ~a & b, so 11->00, 10->10, 01->01,
// 00->00. Define EXPECT_CHECK_EN to also exercise the expected-response checker.
module tb_fsm_ab_driver;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pat_wr_en;
  logic [2:0] pat_wr_addr;
  logic [1:0] pat_wr_data;
  logic [1:0] pat_wr_exp;
  logic [3:0] pat_len;
  logic       y1;
  logic       y0;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       resp_valid;
  logic [1:0] resp_data;
  logic [2:0] resp_idx;
`ifdef EXPECT_CHECK_EN
  logic       mismatch;
  logic [3:0] err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  fsm_ab_driver #(
    .DEPTH      (8),
    .ADDR_W     (3),
    .HOLD_CYCLES(5),
    .CNT_W      (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pat_wr_en  (pat_wr_en),
    .pat_wr_addr(pat_wr_addr),
    .pat_wr_data(pat_wr_data),
    .pat_len    (pat_len),
    .y1         (y1),
    .y0         (y0),
`ifdef EXPECT_CHECK_EN
    .pat_wr_exp (pat_wr_exp),
    .mismatch   (mismatch),
    .err_cnt    (err_cnt),
`endif
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_idx   (resp_idx)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  assign y1 = a & ~b;
  assign y0 = ~a & b;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [2:0] ad, input logic [1:0] d, input logic [1:0] e);
    pat_wr_en   = 1'b1;
    pat_wr_addr = ad;
    pat_wr_data = d;
    pat_wr_exp  = e;
    tick();
    pat_wr_en   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    pat_wr_en = 1'b0;
    pat_wr_addr = '0;
    pat_wr_data = '0;
    pat_wr_exp = '0;
    pat_len = '0;
    repeat (2) tick();
    checks++;
    if ({a, b, busy, done, resp_valid} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b expected=00000", {a, b, busy, done, resp_valid});
    end
    checks++;
    if ({resp_data, resp_idx} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_resp got=%b expected=00000", {resp_data, resp_idx});
    end
    rst = 1'b0;
    tick();
  endtask

  // mem={11,10,00,00}, len=4: 5 clocks per vector, captures at k=5,10,15,20.
  task automatic test_sequence;
    logic [1:0] ab_tab [4];
    logic [1:0] rs_tab [4];
    ab_tab = '{2'b11, 2'b10, 2'b00, 2'b00};
    rs_tab = '{2'b00, 2'b10, 2'b00, 2'b00};
    write_entry(3'd0, 2'b11, 2'b00);
    write_entry(3'd1, 2'b10, 2'b10);
    write_entry(3'd2, 2'b00, 2'b00);
    write_entry(3'd3, 2'b00, 2'b00);
    pat_len = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 21; k++) begin
      logic       e_busy;
      logic [1:0] e_ab;
      logic       e_rv;
      logic       e_done;
      e_busy = (k < 20);
      e_ab   = e_busy ? ab_tab[2'(k / 5)] : 2'b00;
      e_rv   = (k >= 5) && (k % 5 == 0) && (k <= 20);
      e_done = (k == 20);
      checks++;
      if ({busy, a, b, resp_valid, done} !== {e_busy, e_ab, e_rv, e_done}) begin
        failures++;
        $display("FAIL seq_k%0d got=%b expected=%b", k, {busy, a, b, resp_valid, done},
                 {e_busy, e_ab, e_rv, e_done});
      end
      if (e_rv) begin
        checks++;
        if ({resp_idx, resp_data} !== {3'(k / 5 - 1), rs_tab[2'(k / 5 - 1)]}) begin
          failures++;
          $display("FAIL seq_resp_k%0d got idx=%0d data=%b expected idx=%0d data=%b", k,
                   resp_idx, resp_data, k / 5 - 1, rs_tab[2'(k / 5 - 1)]);
        end
        $display("seq resp idx=%0d data=%b", resp_idx, resp_data);
      end
      tick();
    end
  endtask

  // len=0: no busy, done the cycle after the start edge, no response.
  task automatic test_len_zero;
    pat_len = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, done, resp_valid, a, b} !== 5'b01000) begin
      failures++;
      $display("FAIL len0_first got=%b expected=01000", {busy, done, resp_valid, a, b});
    end
    tick();
    checks++;
    if ({busy, done, resp_valid, a, b} !== 5'b00000) begin
      failures++;
      $display("FAIL len0_after got=%b expected=00000", {busy, done, resp_valid, a, b});
    end
    $display("len0 done pulse observed");
    tick();
  endtask

  // len=12 clamps to 8; start and a write to entry 2 mid-run must have no effect.
  task automatic test_clamp;
    logic [1:0] ab_tab [8];
    logic [1:0] rs_tab [8];
    int         n_cap;
    ab_tab = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
    rs_tab = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00};
    for (int i = 0; i < 8; i++) write_entry(3'(i), ab_tab[i], rs_tab[i]);
    n_cap = 0;
    pat_len = 4'd12;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 41; k++) begin
      logic       e_busy;
      logic [1:0] e_ab;
      logic       e_rv;
      logic       e_done;
      e_busy = (k < 40);
      e_ab   = e_busy ? ab_tab[3'(k / 5)] : 2'b00;
      e_rv   = (k >= 5) && (k % 5 == 0) && (k <= 40);
      e_done = (k == 40);
      checks++;
      if ({busy, a, b, resp_valid, done} !== {e_busy, e_ab, e_rv, e_done}) begin
        failures++;
        $display("FAIL clamp_k%0d got=%b expected=%b", k, {busy, a, b, resp_valid, done},
                 {e_busy, e_ab, e_rv, e_done});
      end
      if (resp_valid) n_cap++;
      if (e_rv) begin
        checks++;
        if ({resp_idx, resp_data} !== {3'(k / 5 - 1), rs_tab[3'(k / 5 - 1)]}) begin
          failures++;
          $display("FAIL clamp_resp_k%0d got idx=%0d data=%b expected idx=%0d data=%b", k,
                   resp_idx, resp_data, k / 5 - 1, rs_tab[3'(k / 5 - 1)]);
        end
        $display("clamp resp idx=%0d data=%b", resp_idx, resp_data);
      end
      if (k == 7) begin
        start = 1'b1;
        pat_wr_en = 1'b1;
        pat_wr_addr = 3'd2;
        pat_wr_data = 2'b01;
        pat_wr_exp = 2'b01;
      end else begin
        start = 1'b0;
        pat_wr_en = 1'b0;
      end
      tick();
    end
    checks++;
    if (n_cap !== 8) begin
      failures++;
      $display("FAIL clamp_captures got=%0d expected=8", n_cap);
    end
  endtask

  // Write to entry 0 on the same edge as start: the new data is what plays.
  task automatic test_write_start_same_edge;
    pat_wr_en = 1'b1;
    pat_wr_addr = 3'd0;
    pat_wr_data = 2'b01;
    pat_wr_exp = 2'b01;
    pat_len = 4'd1;
    start = 1'b1;
    tick();
    pat_wr_en = 1'b0;
    start = 1'b0;
    checks++;
    if ({a, b, busy} !== 3'b011) begin
      failures++;
      $display("FAIL wrstart_ab got=%b expected=011", {a, b, busy});
    end
    repeat (4) tick();
    checks++;
    if ({busy, resp_valid} !== 2'b10) begin
      failures++;
      $display("FAIL wrstart_hold got=%b expected=10", {busy, resp_valid});
    end
    tick();
    checks++;
    if ({busy, resp_valid, done, resp_idx, resp_data} !== {3'b011, 3'd0, 2'b01}) begin
      failures++;
      $display("FAIL wrstart_end got=%b expected=%b", {busy, resp_valid, done, resp_idx, resp_data},
               {3'b011, 3'd0, 2'b01});
    end
    $display("wrstart resp idx=%0d data=%b", resp_idx, resp_data);
    tick();
  endtask

  // Async reset at hold=2 clears outputs at once; a restart replays from entry 0.
  // Memory now: entry0=01, entry1=11, entry2=10 (mid-run write was ignored).
  task automatic test_reset_mid_run;
    logic [1:0] ab_tab [4];
    logic [1:0] rs_tab [4];
    ab_tab = '{2'b01, 2'b11, 2'b10, 2'b00};
    rs_tab = '{2'b01, 2'b00, 2'b10, 2'b00};
    pat_len = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({a, b, busy, resp_valid, done} !== 5'b00000) begin
      failures++;
      $display("FAIL midrst_clear got=%b expected=00000", {a, b, busy, resp_valid, done});
    end
    #2;
    rst = 1'b0;
    tick();
    checks++;
    if ({a, b, busy} !== 3'b000) begin
      failures++;
      $display("FAIL midrst_idle got=%b expected=000", {a, b, busy});
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      logic       e_busy;
      logic [1:0] e_ab;
      logic       e_rv;
      logic       e_done;
      e_busy = (k < 15);
      e_ab   = e_busy ? ab_tab[2'(k / 5)] : 2'b00;
      e_rv   = (k >= 5) && (k % 5 == 0) && (k <= 15);
      e_done = (k == 15);
      checks++;
      if ({busy, a, b, resp_valid, done} !== {e_busy, e_ab, e_rv, e_done}) begin
        failures++;
        $display("FAIL midrst_k%0d got=%b expected=%b", k, {busy, a, b, resp_valid, done},
                 {e_busy, e_ab, e_rv, e_done});
      end
      if (e_rv) begin
        checks++;
        if ({resp_idx, resp_data} !== {3'(k / 5 - 1), rs_tab[2'(k / 5 - 1)]}) begin
          failures++;
          $display("FAIL midrst_resp_k%0d got idx=%0d data=%b expected idx=%0d data=%b", k,
                   resp_idx, resp_data, k / 5 - 1, rs_tab[2'(k / 5 - 1)]);
        end
        $display("midrst resp idx=%0d data=%b", resp_idx, resp_data);
      end
      tick();
    end
  endtask

`ifdef EXPECT_CHECK_EN
  // Expected {00,01,00,00} against actual {00,10,00,00}: only entry 1 mismatches.
  task automatic test_expect_check;
    write_entry(3'd0, 2'b11, 2'b00);
    write_entry(3'd1, 2'b10, 2'b01);
    write_entry(3'd2, 2'b00, 2'b00);
    write_entry(3'd3, 2'b00, 2'b00);
    pat_len = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 21; k++) begin
      logic e_mm;
      e_mm = (k == 10);
      checks++;
      if (mismatch !== e_mm) begin
        failures++;
        $display("FAIL exp_mismatch_k%0d got=%b expected=%b", k, mismatch, e_mm);
      end
      if (resp_valid) $display("exp resp idx=%0d data=%b mismatch=%b", resp_idx, resp_data, mismatch);
      if (k >= 20) begin
        checks++;
        if (err_cnt !== 4'd1) begin
          failures++;
          $display("FAIL exp_errcnt_k%0d got=%0d expected=1", k, err_cnt);
        end
      end
      tick();
    end
    pat_len = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err_cnt !== 4'd0) begin
      failures++;
      $display("FAIL exp_errcnt_clear got=%0d expected=0", err_cnt);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_len_zero();
    test_clamp();
    test_write_start_same_edge();
    test_reset_mid_run();
`ifdef EXPECT_CHECK_EN
    test_expect_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
